// File: rtl/p4_pkg.sv
// Shared constants, types and helpers for the pipelined P4 adder.
package p4_pkg;

    localparam int P4_NBITS   = 32;
    localparam int P4_NSTAGES = 4;

    typedef enum logic {
        P4_OP_ADD = 1'b0,
        P4_OP_SUB = 1'b1
    } p4_op_t;

    typedef struct packed {
        logic [P4_NBITS-1:0] sum;
        logic                cout;
        logic                ovf;
    } p4_result_t;

    function automatic int slice_width(input int nbits, input int nstages);
        return nbits / nstages;
    endfunction

endpackage

// File: rtl/p4_slice_add.sv
// Combinational W-bit ripple slice with carry in/out; one instance per pipeline stage.
module p4_slice_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    assign {o_cout, o_sum} = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/p4_pipe_adder.sv
// Pipelined slice adder: one SW-bit slice resolved per clock, carry registered between slices.
// Optional output saturation on signed overflow when P4_PIPE_ADDER_SAT_EN is defined.
module p4_pipe_adder
    import p4_pkg::*;
#(
    parameter int NBITS   = P4_NBITS,
    parameter int NSTAGES = P4_NSTAGES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [NBITS-1:0] a,
    input  logic [NBITS-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [NBITS-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SW = slice_width(NBITS, NSTAGES);

    if ((NSTAGES < 1) || ((NBITS % NSTAGES) != 0)) begin : g_bad_cfg
        $error("p4_pipe_adder: NBITS must be a non-zero multiple of NSTAGES");
    end

    // Register set p feeds stage p; set NSTAGES holds the finished result.
    logic             r_v [NSTAGES+1];
    logic [NBITS-1:0] r_a [NSTAGES+1];
    logic [NBITS-1:0] r_b [NSTAGES+1];
    logic [NBITS-1:0] r_s [NSTAGES+1];
    logic             r_c [NSTAGES+1];

    logic [SW-1:0]    w_slice_sum  [NSTAGES];
    logic             w_slice_cout [NSTAGES];

    p4_op_t           w_op;
    logic [NBITS-1:0] w_b_eff;
    logic             w_cin_eff;
    logic             w_stall;
    logic             w_accept;
    logic [NBITS-1:0] w_sum_raw;
    logic             w_ovf;

    assign w_op      = sub ? P4_OP_SUB : P4_OP_ADD;
    assign w_b_eff   = (w_op == P4_OP_SUB) ? ~b : b;
    assign w_cin_eff = (w_op == P4_OP_SUB) ? 1'b1 : cin;

    // A full output stage that is not being drained freezes every stage, bubbles included.
    assign w_stall  = r_v[NSTAGES] && !out_ready;
    assign in_ready = !w_stall && !rst;
    assign w_accept = in_valid && in_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGES; gi++) begin : g_slice
            p4_slice_add #(.W(SW)) u_add (
                .i_a    (r_a[gi][gi*SW +: SW]),
                .i_b    (r_b[gi][gi*SW +: SW]),
                .i_cin  (r_c[gi]),
                .o_sum  (w_slice_sum[gi]),
                .o_cout (w_slice_cout[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int p = 0; p <= NSTAGES; p++) begin
                r_v[p] <= 1'b0;
                r_a[p] <= '0;
                r_b[p] <= '0;
                r_s[p] <= '0;
                r_c[p] <= 1'b0;
            end
        end else if (!w_stall) begin
            r_v[0] <= w_accept;
            if (w_accept) begin
                r_a[0] <= a;
                r_b[0] <= w_b_eff;
                r_s[0] <= '0;
                r_c[0] <= w_cin_eff;
            end
            for (int k = 0; k < NSTAGES; k++) begin
                r_v[k+1]               <= r_v[k];
                r_a[k+1]               <= r_a[k];
                r_b[k+1]               <= r_b[k];
                r_c[k+1]               <= w_slice_cout[k];
                r_s[k+1]               <= r_s[k];
                r_s[k+1][k*SW +: SW]   <= w_slice_sum[k];
            end
        end
    end

    assign w_sum_raw = r_s[NSTAGES];
    assign w_ovf     = (r_a[NSTAGES][NBITS-1] == r_b[NSTAGES][NBITS-1]) &&
                       (w_sum_raw[NBITS-1] != r_a[NSTAGES][NBITS-1]);

    assign out_valid = r_v[NSTAGES];
    assign cout      = r_c[NSTAGES];
    assign ovf       = w_ovf;

`ifdef P4_PIPE_ADDER_SAT_EN
    // Clamp toward the sign of A: negative operands saturate to the most negative value.
    always_comb begin
        sum = w_sum_raw;
        if (w_ovf) begin
            sum = r_a[NSTAGES][NBITS-1] ? {1'b1, {(NBITS-1){1'b0}}}
                                        : {1'b0, {(NBITS-1){1'b1}}};
        end
    end
`else
    assign sum = w_sum_raw;
`endif

endmodule

// File: tb/tb_p4_pipe_adder.sv
// Scoreboard bench for p4_pipe_adder: main 4-stage instance plus 1- and 32-stage instances.
module tb_p4_pipe_adder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        out_ready;

    logic        in_ready, out_valid, cout, ovf;
    logic [31:0] sum;
    logic        in_ready1, out_valid1, cout1, ovf1;
    logic [31:0] sum1;
    logic        in_ready32, out_valid32, cout32, ovf32;
    logic [31:0] sum32;

    int checks    = 0;
    int errors    = 0;
    int pop_count = 0;

    typedef struct packed {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    p4_pipe_adder #(.NBITS(32), .NSTAGES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout), .ovf(ovf)
    );

    p4_pipe_adder #(.NBITS(32), .NSTAGES(1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid1), .out_ready(out_ready),
        .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    p4_pipe_adder #(.NBITS(32), .NSTAGES(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready32),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid32), .out_ready(out_ready),
        .sum(sum32), .cout(cout32), .ovf(ovf32)
    );

    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic mcin, input logic msub);
        exp_t        r;
        logic [31:0] beff;
        logic [32:0] full;
        beff   = msub ? ~mb : mb;
        full   = {1'b0, ma} + {1'b0, beff} + {32'd0, (msub ? 1'b1 : mcin)};
        r.sum  = full[31:0];
        r.cout = full[32];
        r.ovf  = (ma[31] == beff[31]) && (full[31] != ma[31]);
`ifdef P4_PIPE_ADDER_SAT_EN
        if (r.ovf) r.sum = ma[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
`endif
        return r;
    endfunction

    // Scoreboard, handshake and stall-hold monitor for the main instance.
    logic        prev_stall = 1'b0;
    logic [31:0] held_sum;
    logic        held_cout, held_ovf;

    always @(negedge clk) begin
        exp_t e;
        if (rst !== 1'b0) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            checks++;
            if (in_ready !== !(out_valid && !out_ready)) begin
                errors++;
                $display("FAIL in_ready: got %b, expected %b (out_valid=%b out_ready=%b)",
                         in_ready, !(out_valid && !out_ready), out_valid, out_ready);
            end
            if (prev_stall) begin
                checks++;
                if ({out_valid, sum, cout, ovf} !== {1'b1, held_sum, held_cout, held_ovf}) begin
                    errors++;
                    $display("FAIL stall_hold: got v=%b sum=%h cout=%b ovf=%b, expected v=1 sum=%h cout=%b ovf=%b",
                             out_valid, sum, cout, ovf, held_sum, held_cout, held_ovf);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL sb_unexpected: got result sum=%h, expected no result", sum);
                end else begin
                    e = exp_q.pop_front();
                    pop_count++;
                    if ({sum, cout, ovf} !== {e.sum, e.cout, e.ovf}) begin
                        errors++;
                        $display("FAIL sb_data: got sum=%h cout=%b ovf=%b, expected sum=%h cout=%b ovf=%b",
                                 sum, cout, ovf, e.sum, e.cout, e.ovf);
                    end else begin
                        $display("result #%0d sum=%h cout=%b ovf=%b", pop_count, sum, cout, ovf);
                    end
                end
            end
            prev_stall = out_valid && !out_ready;
            held_sum   = sum;
            held_cout  = cout;
            held_ovf   = ovf;
        end
    end

    // Presents one beat and returns one posedge (+1) after it was accepted.
    task automatic drive_beat(input logic [31:0] ta, input logic [31:0] tbv,
                              input logic tcin, input logic tsub);
        int n = 0;
        a = ta; b = tbv; cin = tcin; sub = tsub; in_valid = 1'b1;
        @(negedge clk);
        while (in_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (in_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=%b, expected 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycles after the accepting edge until out_valid is seen; -1 on timeout.
    task automatic wait_out(output int lat);
        lat = -1;
        for (int c = 1; c <= 64; c++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({out_valid, sum, cout, ovf, in_ready} !== 35'd0) begin
            errors++;
            $display("FAIL reset_state: got v=%b sum=%h cout=%b ovf=%b rdy=%b, expected all 0",
                     out_valid, sum, cout, ovf, in_ready);
        end
        checks++;
        if ({out_valid1, out_valid32, in_ready1, in_ready32} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_aux: got v1=%b v32=%b r1=%b r32=%b, expected 0000",
                     out_valid1, out_valid32, in_ready1, in_ready32);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b v=%b, expected rdy=1 v=0", in_ready, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_carry_chain;
        int          lat4 = -1, lat1 = -1, lat32 = -1;
        logic [33:0] r4 = '0, r1 = '0, r32 = '0;
        drive_beat(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0);
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); @(negedge clk);
            if (out_valid   === 1'b1 && lat4  < 0) begin lat4  = c; r4  = {sum, cout, ovf};     end
            if (out_valid1  === 1'b1 && lat1  < 0) begin lat1  = c; r1  = {sum1, cout1, ovf1};   end
            if (out_valid32 === 1'b1 && lat32 < 0) begin lat32 = c; r32 = {sum32, cout32, ovf32}; end
        end
        checks += 3;
        if (lat4 !== 4)   begin errors++; $display("FAIL carry_lat_n4: got %0d, expected 4", lat4);   end
        if (lat1 !== 1)   begin errors++; $display("FAIL carry_lat_n1: got %0d, expected 1", lat1);   end
        if (lat32 !== 32) begin errors++; $display("FAIL carry_lat_n32: got %0d, expected 32", lat32); end
        checks += 3;
        if (r4 !== {32'h0, 1'b1, 1'b0})  begin errors++; $display("FAIL carry_n4: got %h, expected sum=0 cout=1 ovf=0", r4);   end
        if (r1 !== {32'h0, 1'b1, 1'b0})  begin errors++; $display("FAIL carry_n1: got %h, expected sum=0 cout=1 ovf=0", r1);   end
        if (r32 !== {32'h0, 1'b1, 1'b0}) begin errors++; $display("FAIL carry_n32: got %h, expected sum=0 cout=1 ovf=0", r32); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic;
        int lat;
        drive_beat(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        wait_out(lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL basic_latency: got %0d, expected 4", lat); end
        checks++;
        if ({sum, cout, ovf} !== {32'h0000_0100, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_sum: got sum=%h cout=%b ovf=%b, expected sum=00000100 cout=0 ovf=0", sum, cout, ovf);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_sub_ovf;
        int          lat;
        logic [31:0] exp_sat;
`ifdef P4_PIPE_ADDER_SAT_EN
        exp_sat = 32'h7FFF_FFFF;
`else
        exp_sat = 32'h8000_0000;
`endif
        drive_beat(32'd5, 32'd7, 1'b1, 1'b1);
        wait_out(lat);
        checks++;
        if (lat !== 4 || {sum, cout, ovf} !== {32'hFFFF_FFFE, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sub_5_7: got lat=%0d sum=%h cout=%b ovf=%b, expected lat=4 sum=fffffffe cout=0 ovf=0",
                     lat, sum, cout, ovf);
        end
        @(posedge clk); #1;
        drive_beat(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0);
        wait_out(lat);
        checks++;
        if (lat !== 4 || {sum, cout, ovf} !== {exp_sat, 1'b0, 1'b1}) begin
            errors++;
            $display("FAIL add_ovf: got lat=%0d sum=%h cout=%b ovf=%b, expected lat=4 sum=%h cout=0 ovf=1",
                     lat, sum, cout, ovf, exp_sat);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_stream;
        int acc = 0, n = 0, stalls = 0;
        int p0  = pop_count;
        out_ready = 1'b1;
        while (acc < 16 && n < 200) begin
            a = $urandom; b = $urandom;
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready === 1'b1) acc++;
            else stalls++;
            @(posedge clk); #1;
            out_ready = ~out_ready;
            n++;
        end
        in_valid = 1'b0;
        n = 0;
        while ((exp_q.size() != 0 || out_valid === 1'b1) && n < 200) begin
            @(posedge clk); #1;
            out_ready = ~out_ready;
            n++;
        end
        out_ready = 1'b1;
        checks++;
        if (pop_count - p0 !== 16) begin
            errors++;
            $display("FAIL stream_count: got %0d results, expected 16", pop_count - p0);
        end
        checks++;
        if (stalls == 0) begin
            errors++;
            $display("FAIL stream_backpressure: got %0d stalled cycles, expected at least 1", stalls);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_midstream;
        int lat;
        int p0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = 32'h100 + i; b = 32'h10; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %b, expected 0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_flush: got out_valid=%b, expected 0", out_valid); end
        p0 = pop_count;
        @(posedge clk); #1;
        drive_beat(32'd1, 32'd2, 1'b0, 1'b0);
        wait_out(lat);
        checks++;
        if (lat !== 4 || sum !== 32'd3) begin
            errors++;
            $display("FAIL rst_after_beat: got lat=%0d sum=%h, expected lat=4 sum=00000003", lat, sum);
        end
        repeat (8) @(posedge clk);
        #1;
        checks++;
        if (pop_count - p0 !== 1) begin
            errors++;
            $display("FAIL rst_discard: got %0d results after reset, expected 1", pop_count - p0);
        end
    endtask

    task automatic test_bubbles;
        logic [3:0] pat = 4'b1001;
        out_ready = 1'b1;
        a = 32'h1234; b = 32'h1; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        a = 32'h4321; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== pat[3-i]) begin
                errors++;
                $display("FAIL bubble_%0d: got out_valid=%b, expected %b", i, out_valid, pat[3-i]);
            end
        end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset;
        test_carry_chain;
        test_basic;
        test_sub_ovf;
        test_stream;
        test_reset_midstream;
        test_bubbles;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d pending results, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/p4_pipe_adder.md
Name: p4_pipe_adder

Overview:
- Parametrised, pipelined successor to the P4 sparse-tree adder: NBITS operands split into NSTAGES equal slices, one slice resolved per clock, carry registered between slices.
- Adds add/subtract mode, signed-overflow flag and a valid/ready stream handshake with backpressure.
- Sits behind the ALU operand mux; results are consumed by the writeback buffer.

Parameters:
- NBITS, 32, operand/result width; must be a multiple of NSTAGES.
- NSTAGES, 4, pipeline depth and slice count; 1..NBITS. Slice width SW = NBITS/NSTAGES.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  NBITS  operand A.
- b  input  NBITS  operand B.
- cin  input  1  carry-in, used only when sub=0.
- sub  input  1  0: a+b+cin; 1: a+~b+1 (cin ignored).
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  NBITS  result.
- cout  output  1  raw carry out of the MSB.
- ovf  output  1  signed two's-complement overflow.

Behaviour:
- Reset: one clock is synchronous and rst is active-high, sampled on the clk rising edge. While rst=1, all stage valid bits, out_valid, sum, cout and ovf clear to 0; in_ready=0 during reset.
- Accept: accept = in_valid && in_ready. Operand B is inverted and carry-in forced to 1 when sub=1.
- Stage k (0..NSTAGES-1) adds bits [k*SW +: SW] of A and effective B plus the registered carry from stage k-1; stage 0 uses the effective carry-in.
- Upper operand slices are delayed alongside; lower result slices are delayed to realign.
- Latency: result for a beat accepted at edge t has out_valid=1 after edge t+NSTAGES. Throughput is 1 beat/cycle.
- Stall = out_valid && !out_ready. in_ready = !stall && !rst. On stall the whole pipeline holds, including bubbles; bubbles are not collapsed.
- sum, cout and ovf stay stable while out_valid && !out_ready.
- Ordering: strictly in order; no loss or duplication.
- ovf = (MSB of A == MSB of effective B) && (MSB of sum != MSB of A).
- rst mid-stream: all in-flight beats are discarded. The first beat accepted after release appears NSTAGES cycles later.
- When out_valid=0, the values of sum, cout and ovf are don't-care but must be deterministic; the data registers are not cleared except by rst.

Optional Feature:
- Macro: P4_PIPE_ADDER_SAT_EN.
- Defined: when ovf=1, sum saturates to 0x7FF..F if A is non-negative, otherwise to 0x800..0. ovf and cout are still reported unchanged.
- Undefined: sum is the wrapped result; no saturation logic is generated.

Decomposition:
- Package p4_pkg holds:
  - default constants P4_NBITS=32 and P4_NSTAGES=4;
  - function slice_width(nbits, nstages);
  - typedef enum logic {P4_OP_ADD, P4_OP_SUB} p4_op_t;
  - the result struct typedef {sum, cout, ovf}.
- Sub-module p4_slice_add: combinational SW-bit adder with cin/cout, instantiated NSTAGES times by a generate loop.
- Elaboration assertion: NBITS % NSTAGES == 0.

Test Plan (NBITS=32, NSTAGES=4 unless stated):
1. a=0x0000_00FF, b=0x0000_0001, cin=0, sub=0, out_ready=1 -> sum=0x0000_0100, cout=0, ovf=0; out_valid exactly 4 cycles after accept.
2. Full carry chain through every slice: a=0xFFFF_FFFF, b=0, cin=1 -> sum=0x0000_0000, cout=1, ovf=0. Repeat with NSTAGES=1 and NSTAGES=32 for the same result.
3. Subtract and overflow:
   - a=5, b=7, sub=1 -> sum=0xFFFF_FFFE, cout=0, ovf=0.
   - a=0x7FFF_FFFF, b=1, sub=0 -> sum=0x8000_0000, ovf=1; with P4_PIPE_ADDER_SAT_EN, sum=0x7FFF_FFFF.
4. Stream of 16 random beats, in_valid always 1, out_ready toggling 1,0,1,0 -> 16 results in order matching the reference model; in_ready=0 exactly in cycles where out_valid=1 and out_ready=0; outputs stable during stall.
5. rst=1 for 1 cycle with 3 beats in flight -> next cycle out_valid=0 and none of the 3 results ever appear. A beat a=1, b=2 accepted after release gives sum=3 four cycles later.
6. Bubble pattern in_valid 1,0,0,1 with out_ready=1 -> out_valid pattern 1,0,0,1 starting 4 cycles after the first accept.
